// File: rtl/pattern_det_pkg.sv
// Shared constants for the serial pattern detector: default sizing, reset
// pattern and the ui_in pin map.
package pattern_det_pkg;

  localparam int PAT_W_DEF = 8;
  localparam int LEN_W_DEF = 3;
  localparam int CNT_W_DEF = 6;

  localparam logic [7:0] DEFAULT_PAT = 8'h0B;
  localparam int         DEFAULT_LEN = 4;

  // ui_in bit positions
  localparam int DIN     = 0;
  localparam int VALID   = 1;
  localparam int OVL     = 2;
  localparam int LOAD    = 3;
  localparam int LEN_LSB = 4;
  localparam int CNT_CLR = 7;

  // Low 'len' bits set; sized for the largest supported pattern (8 bits).
  function automatic logic [7:0] len_mask(input logic [3:0] len);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < 8; i++)
      m[i] = (4'(i) < len);
    return m;
  endfunction

endpackage

// File: rtl/pattern_match_core.sv
// Shift history, fill tracking and Mealy compare against the loaded pattern.
module pattern_match_core
  import pattern_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din_i,
  input  logic             valid_i,
  input  logic             load_i,
  input  logic             ovl_i,
  input  logic [PAT_W-1:0] pat_i,
  input  logic [LEN_W:0]   len_i,
  output logic             match_o
);

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W - 1);

  logic [PAT_W-1:0] hist_q, hist_d;
  logic [LEN_W-1:0] fill_q, fill_d;
  logic [PAT_W-1:0] cand;
  logic [PAT_W-1:0] mask;
  logic [7:0]       mask_full;
  logic [LEN_W:0]   len_m1;
  logic             full;

  assign mask_full = len_mask(4'(len_i));
  assign mask      = mask_full[PAT_W-1:0];
  assign cand      = {hist_q[PAT_W-2:0], din_i};
  assign len_m1    = len_i - (LEN_W+1)'(1);
  // Enough earlier bits are held to complete a pattern with the current din
  assign full      = ({1'b0, fill_q} >= len_m1);
  assign match_o   = valid_i & ~load_i & full & (((cand ^ pat_i) & mask) == '0);

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (load_i) begin
      hist_d = '0;
      fill_d = '0;
    end else if (valid_i) begin
      hist_d = cand;
      if (match_o && !ovl_i)
        fill_d = '0;
      else if (fill_q != FILL_MAX)
        fill_d = fill_q + LEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/tt_um_pattern_detector.sv
// Tiny Tapeout top: pin mapping, loadable pattern/length/mode, registered
// match pulse and wrapping match counter around the match core.
module tt_um_pattern_detector
  import pattern_det_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic             din, valid, load, cnt_clr;
  logic             match;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W:0]   len_q, len_d;
  logic             ovl_q, ovl_d;
  logic             mq_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             unused_ok;

  assign din     = ui_in[DIN];
  assign valid   = ui_in[VALID];
  assign load    = ui_in[LOAD];
  assign cnt_clr = ui_in[CNT_CLR];

  assign unused_ok = &{1'b0, ena};

  always_comb begin
    pat_d = pat_q;
    len_d = len_q;
    ovl_d = ovl_q;
    if (load) begin
      pat_d = uio_in[PAT_W-1:0];
      len_d = (LEN_W+1)'(ui_in[LEN_LSB +: LEN_W]) + (LEN_W+1)'(1);
      ovl_d = ui_in[OVL];
    end
  end

  // Clear wins over a simultaneous match
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr)
      cnt_d = '0;
    else if (match)
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pat_q <= PAT_W'(DEFAULT_PAT);
      len_q <= (LEN_W+1)'(DEFAULT_LEN);
      ovl_q <= 1'b1;
      mq_q  <= 1'b0;
      cnt_q <= '0;
    end else begin
      pat_q <= pat_d;
      len_q <= len_d;
      ovl_q <= ovl_d;
      mq_q  <= match;
      cnt_q <= cnt_d;
    end
  end

  pattern_match_core #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_core (
    .clk     (clk),
    .rst_n   (rst_n),
    .din_i   (din),
    .valid_i (valid),
    .load_i  (load),
    .ovl_i   (ovl_q),
    .pat_i   (pat_q),
    .len_i   (len_q),
    .match_o (match)
  );

  assign uo_out  = 8'({cnt_q, mq_q, match});
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_pattern_detector.sv
// Bench for tt_um_pattern_detector: directed vector table, corner sequences
// and a randomized stream against a queue-based reference model.
module tb_tt_um_pattern_detector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  always #5 clk = ~clk;

  tt_um_pattern_detector dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: bits received since the last load/reset (or since the
  // last match in non-overlap mode), newest at the back.
  bit         q[$];
  logic [7:0] m_pat;
  int         m_len;
  bit         m_ovl;
  bit         m_mq;
  int         m_cnt;

  typedef struct {
    logic [7:0] ui;
    logic [7:0] uio;
    logic       m;
    logic       mq;
    logic [5:0] cnt;
  } vec_t;

  vec_t vec[17];

  function automatic logic [7:0] mk(bit din, bit vld, bit ovl, bit ld,
                                    int lenm1, bit clr);
    logic [2:0] l;
    l = 3'(lenm1);
    return {clr, l, ld, ovl, vld, din};
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit model_match(bit din, bit vld, bit ld);
    bit b;
    if (!vld || ld) return 1'b0;
    if (q.size() < m_len - 1) return 1'b0;
    for (int k = 0; k < m_len; k++) begin
      b = (k == 0) ? din : q[q.size() - k];
      if (b != m_pat[k]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    q.delete();
    m_pat = 8'h0B;
    m_len = 4;
    m_ovl = 1'b1;
    m_mq  = 1'b0;
    m_cnt = 0;
  endtask

  // One clock: drive, sample at negedge, check against model, advance model.
  task automatic cyc(input bit r, input logic [7:0] ui, input logic [7:0] pv,
                     output bit mo, output bit mqo, output int co);
    bit em;
    rst_n  = r;
    ui_in  = ui;
    uio_in = pv;
    @(negedge clk);
    mo  = uo_out[0];
    mqo = uo_out[1];
    co  = int'(uo_out[7:2]);
    em  = model_match(ui[0], ui[1], ui[3]);
    if (r) begin
      chk("model_match", int'(mo), int'(em));
      chk("model_match_q", int'(mqo), int'(m_mq));
      chk("model_count", co, m_cnt);
    end
    @(posedge clk);
    if (!r) begin
      model_reset();
    end else begin
      m_mq = em;
      if (ui[7])   m_cnt = 0;
      else if (em) m_cnt = (m_cnt + 1) % 64;
      if (ui[3]) begin
        m_pat = pv;
        m_len = int'(ui[6:4]) + 1;
        m_ovl = ui[2];
        q.delete();
      end else if (ui[1]) begin
        if (em && !m_ovl) q.delete();
        else begin
          q.push_back(ui[0]);
          if (q.size() > 8) void'(q.pop_front());
        end
      end
    end
    #1;
  endtask

  task automatic send(input bit din, output bit mo);
    bit mqo;
    int co;
    cyc(1'b1, mk(din, 1, 0, 0, 0, 0), 8'h00, mo, mqo, co);
  endtask

  task automatic idle(output bit mqo, output int co);
    bit mo;
    cyc(1'b1, 8'h00, 8'h00, mo, mqo, co);
  endtask

  task automatic do_load(input logic [7:0] pv, input int lenm1, input bit ovl);
    bit mo, mqo;
    int co;
    cyc(1'b1, mk(0, 1, ovl, 1, lenm1, 0), pv, mo, mqo, co);
    chk("load_forces_no_match", int'(mo), 0);
  endtask

  initial begin
    bit   mo, mqo;
    int   co, hits, c0;
    bit   a5 [8];
    bit   r, ld, clr, vld, din, ovl;
    int   lm;

    ena = 1'b1;
    rst_n = 1'b0;
    ui_in = 8'h00;
    uio_in = 8'h00;
    model_reset();

    // Defaults stream (overlap), then load non-overlap and repeat
    vec[0]  = '{mk(1,1,0,0,0,0), 8'h00, 0, 0, 0};
    vec[1]  = '{mk(0,1,0,0,0,0), 8'h00, 0, 0, 0};
    vec[2]  = '{mk(1,1,0,0,0,0), 8'h00, 0, 0, 0};
    vec[3]  = '{mk(1,1,0,0,0,0), 8'h00, 1, 0, 0};
    vec[4]  = '{mk(0,1,0,0,0,0), 8'h00, 0, 1, 1};
    vec[5]  = '{mk(1,1,0,0,0,0), 8'h00, 0, 0, 1};
    vec[6]  = '{mk(1,1,0,0,0,0), 8'h00, 1, 0, 1};
    vec[7]  = '{mk(0,0,0,0,0,0), 8'h00, 0, 1, 2};
    vec[8]  = '{mk(0,0,0,1,3,0), 8'h0B, 0, 0, 2};
    vec[9]  = '{mk(1,1,0,0,0,0), 8'h00, 0, 0, 2};
    vec[10] = '{mk(0,1,0,0,0,0), 8'h00, 0, 0, 2};
    vec[11] = '{mk(1,1,0,0,0,0), 8'h00, 0, 0, 2};
    vec[12] = '{mk(1,1,0,0,0,0), 8'h00, 1, 0, 2};
    vec[13] = '{mk(0,1,0,0,0,0), 8'h00, 0, 1, 3};
    vec[14] = '{mk(1,1,0,0,0,0), 8'h00, 0, 0, 3};
    vec[15] = '{mk(1,1,0,0,0,0), 8'h00, 0, 0, 3};
    vec[16] = '{mk(0,0,0,0,0,0), 8'h00, 0, 0, 3};

    // Reset for two cycles
    cyc(1'b0, 8'h00, 8'h00, mo, mqo, co);
    cyc(1'b0, 8'h00, 8'h00, mo, mqo, co);
    rst_n = 1'b1;
    #1;
    chk("reset_uo_out", int'(uo_out), 0);
    chk("uio_out_zero", int'(uio_out), 0);
    chk("uio_oe_zero", int'(uio_oe), 0);

    for (int i = 0; i < 17; i++) begin
      cyc(1'b1, vec[i].ui, vec[i].uio, mo, mqo, co);
      chk($sformatf("vec%0d_match", i), int'(mo), int'(vec[i].m));
      chk($sformatf("vec%0d_match_q", i), int'(mqo), int'(vec[i].mq));
      chk($sformatf("vec%0d_count", i), co, int'(vec[i].cnt));
    end

    // Valid gaps do not break a partial match
    do_load(8'h0B, 3, 1);
    send(1, mo); idle(mqo, co);
    send(0, mo); idle(mqo, co); idle(mqo, co);
    send(1, mo); idle(mqo, co);
    send(1, mo);
    chk("gap_match", int'(mo), 1);

    // Load mid-pattern discards the partial match
    send(0, mo);
    send(1, mo); send(0, mo); send(1, mo);
    do_load(8'h0B, 3, 1);
    send(1, mo);
    chk("load_abort_no_match", int'(mo), 0);

    // Full-width pattern 10100101
    do_load(8'hA5, 7, 1);
    a5 = '{1, 0, 1, 0, 0, 1, 0, 1};
    for (int i = 0; i < 8; i++) begin
      send(a5[i], mo);
      chk($sformatf("len8_bit%0d", i + 1), int'(mo), (i == 7) ? 1 : 0);
    end

    // Single-bit pattern; upper uio_in bits must be masked off
    do_load(8'hFD, 0, 0);
    hits = 0;
    send(1, mo); hits += int'(mo);
    send(1, mo); hits += int'(mo);
    send(0, mo); hits += int'(mo);
    send(1, mo); hits += int'(mo);
    chk("len1_hits", hits, 3);

    // Counter wrap after 64 matches
    cyc(1'b1, mk(0, 0, 0, 0, 0, 1), 8'h00, mo, mqo, co);
    for (int i = 0; i < 64; i++) send(1, mo);
    idle(mqo, co);
    chk("wrap_count", co, 0);
    chk("wrap_match_q", int'(mqo), 1);

    // Clear coinciding with a match
    send(1, mo); send(1, mo);
    idle(mqo, co);
    chk("pre_clr_count", co, 2);
    cyc(1'b1, mk(1, 1, 0, 0, 0, 1), 8'h00, mo, mqo, co);
    chk("clr_cycle_match", int'(mo), 1);
    idle(mqo, co);
    chk("clr_count", co, 0);
    chk("clr_match_q", int'(mqo), 1);

    // Randomized stream against the model
    do_load(8'h0B, 3, 1);
    c0 = n_cmp;
    for (int i = 0; i < 1500; i++) begin
      r   = ($urandom_range(0, 199) != 0);
      ld  = ($urandom_range(0, 24) == 0);
      clr = ($urandom_range(0, 39) == 0);
      vld = ($urandom_range(0, 9) < 7);
      din = 1'($urandom);
      ovl = 1'($urandom);
      lm  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 3);
      cyc(r, mk(din, vld, ovl, ld, lm, clr), 8'($urandom), mo, mqo, co);
    end
    chk("random_checks_ran", (n_cmp - c0) > 3000 ? 1 : 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
